ps2_key_decoder: RTL and testbench

- Parametrised, fully sys_clk-synchronous PS/2 keyboard front end; samples the raw ps2_clk/ps2_data lines directly, with no clock-domain crossing of multi-bit words.
- Deglitches and frames each 11-bit PS/2 byte, checks parity and stop bit, and handles E0 (extended) and F0 (break) prefixes.
- Maps events onto NUM_KEYS programmable keys with held levels and one-per-push press/release pulses.
- Also buffers raw key events in a small FIFO for game/menu logic.

---
 rtl/ps2_key_decoder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: line filter, frame decoder,
// key map with held/press/release pulses and event FIFO.
module ps2_key_decoder #(
  parameter int NUM_KEYS = 8,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {
    9'h175, 9'h01E, 9'h016, 9'h05A,
    9'h01B, 9'h01D, 9'h023, 9'h01C
  },
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                evt_valid,
  output logic [7:0]          evt_code,
  output logic                evt_ext,
  output logic                evt_brk,
  input  logic                evt_ready,
  output logic                frame_err,
  output logic                fifo_ovf
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_PAR  = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  localparam int FW = (FILTER_LEN > 1) ?
                      $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [FW-1:0] FLT_MAX =
    FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX =
    TW'(TIMEOUT_CYC - 1);

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_s;
  logic          dat_s;
  logic          clk_flt;
  logic          clk_flt_d;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] to_cnt;
  logic          timeout;

  logic          byte_vld;
  logic [7:0]    byte_q;
  logic          is_e0;
  logic          is_f0;
  logic          evt_fire;
  logic          ext_q;
  logic          brk_q;
  evt_t          new_evt;

  evt_t          mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  evt_t          head;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // Two-stage synchronisers, idle-high after reset.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Clock filter: follow only a run of differing samples.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_flt <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s != clk_flt) begin
      if (flt_cnt == FLT_MAX) begin
        clk_flt <= clk_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end else begin
      flt_cnt <= '0;
    end
  end

  // Delayed filtered clock for falling-edge detect.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) clk_flt_d <= 1'b1;
    else        clk_flt_d <= clk_flt;
  end

  assign fall = clk_flt_d & ~clk_flt;

  assign timeout = (state != ST_IDLE) && !fall &&
                   (to_cnt == TO_MAX);

  // Cycles since the last edge while a frame is open.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (fall || state == ST_IDLE)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  // Frame FSM: start, 8 data LSB first, parity, stop.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_ok    <= 1'b0;
      byte_vld  <= 1'b0;
      byte_q    <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (timeout) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
      end else if (fall) begin
        unique case (state)
          ST_IDLE: begin
            if (!dat_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PAR;
          end
          ST_PAR: begin
            par_ok <= ^{shreg, dat_s};
            state  <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (dat_s && par_ok) begin
              byte_vld <= 1'b1;
              byte_q   <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign is_e0    = (byte_q == 8'hE0);
  assign is_f0    = (byte_q == 8'hF0);
  assign evt_fire = byte_vld && !is_e0 && !is_f0;
  assign new_evt  = '{ext: ext_q, brk: brk_q,
                      code: byte_q};

  // Prefix flags; any error or completed event clears them.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (frame_err) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (byte_vld) begin
      unique case (1'b1)
        is_e0:   ext_q <= 1'b1;
        is_f0:   brk_q <= 1'b1;
        default: begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      endcase
    end
  end

  // Key map: held level plus edge pulses per matching entry.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      key_held    <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key_press   <= '0;
      key_release <= '0;
      if (evt_fire) begin
        for (int i = 0; i < NUM_KEYS; i++) begin
          if (KEY_CODES[9*i +: 9] == {ext_q, byte_q}) begin
            if (!brk_q && !key_held[i]) begin
              key_held[i]  <= 1'b1;
              key_press[i] <= 1'b1;
            end else if (brk_q && key_held[i]) begin
              key_held[i]    <= 1'b0;
              key_release[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && evt_ready;
  assign push       = evt_fire && (!fifo_full || pop);
  assign head       = mem[rd_ptr[AW-1:0]];

  // Event FIFO; a pop in the push cycle frees the slot.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_ovf <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      fifo_ovf <= evt_fire && fifo_full && !pop;
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= new_evt;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign evt_valid = !fifo_empty;
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_brk   = head.brk;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: table vectors, directed
// corner sequences and random frames against a byte model.
module tb_ps2_key_decoder;

  localparam int NK = 8;
  localparam int FL = 8;
  localparam int TO = 2000;
  localparam int FD = 4;
  localparam int H  = 20;
  localparam logic [NK*9-1:0] KC = {
    9'h175, 9'h01E, 9'h016, 9'h05A,
    9'h01B, 9'h01D, 9'h023, 9'h01C
  };

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          evt_ready = 1'b0;
  logic [NK-1:0] key_held;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic          evt_valid;
  logic [7:0]    evt_code;
  logic          evt_ext;
  logic          evt_brk;
  logic          frame_err;
  logic          fifo_ovf;

  ps2_key_decoder #(
    .NUM_KEYS(NK), .KEY_CODES(KC),
    .FILTER_LEN(FL), .TIMEOUT_CYC(TO),
    .FIFO_DEPTH(FD)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_held(key_held), .key_press(key_press),
    .key_release(key_release),
    .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_brk(evt_brk),
    .evt_ready(evt_ready),
    .frame_err(frame_err), .fifo_ovf(fifo_ovf)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [NK*9-1:0] kc_v = KC;
  bit              m_ext, m_brk;
  bit [NK-1:0]     m_held;
  int              m_press [NK];
  int              m_rel [NK];
  int              m_err, m_ovf;
  logic [9:0]      mq [$];

  // observed pulse counts
  int            o_press [NK];
  int            o_rel [NK];
  int            o_err, o_ovf;
  int            last_press_cyc, fall_cyc;
  logic [NK-1:0] prev_press = '0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    logic [9:0] e;
    if (rst_n) begin
      for (int i = 0; i < NK; i++) begin
        if (key_press[i])   o_press[i]++;
        if (key_release[i]) o_rel[i]++;
      end
      if (frame_err) o_err++;
      if (fifo_ovf)  o_ovf++;
      if (key_press != '0) begin
        last_press_cyc = cyc;
        chk("press_width", key_press & prev_press, 0);
      end
      prev_press = key_press;
      if (evt_valid && evt_ready) begin
        e = (mq.size() != 0) ? mq.pop_front() : 10'h3FF;
        chk("pop_head", {evt_ext, evt_brk, evt_code}, e);
      end
    end else begin
      prev_press = '0;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic model_byte(logic [7:0] b, bit good);
    if (!good) begin
      m_err++;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (mq.size() < FD) mq.push_back({m_ext, m_brk, b});
      else                m_ovf++;
      for (int i = 0; i < NK; i++) begin
        if (kc_v[9*i +: 9] == {m_ext, b}) begin
          if (!m_brk && !m_held[i]) begin
            m_held[i] = 1;
            m_press[i]++;
          end else if (m_brk && m_held[i]) begin
            m_held[i] = 0;
            m_rel[i]++;
          end
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic bitx(bit v, bit rdy);
    ps2_data = v;
    repeat (H) tick();
    ps2_clk = 1'b0;
    fall_cyc = cyc;
    for (int k = 1; k <= H; k++) begin
      tick();
      if (rdy && k == 9)  evt_ready = 1'b1;
      if (rdy && k == 12) evt_ready = 1'b0;
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send(logic [7:0] b, bit bp, bit bs,
                      bit rdy);
    bitx(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bitx(b[i], 1'b0);
    bitx(~^b ^ bp, 1'b0);
    bitx(~bs, rdy);
    ps2_data = 1'b1;
    repeat (H) tick();
    model_byte(b, !bp && !bs);
  endtask

  task automatic pop();
    tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < FD + 2; k++)
      if (mq.size() != 0) pop();
    tick();
    chk("drain_empty", evt_valid, 0);
  endtask

  task automatic check_state(string tag);
    chk({tag, ".held"}, key_held, m_held);
    for (int i = 0; i < NK; i++) begin
      chk($sformatf("%s.press%0d", tag, i),
          o_press[i], m_press[i]);
      chk($sformatf("%s.rel%0d", tag, i),
          o_rel[i], m_rel[i]);
    end
    chk({tag, ".err"}, o_err, m_err);
    chk({tag, ".ovf"}, o_ovf, m_ovf);
    chk({tag, ".valid"}, evt_valid, mq.size() != 0);
    if (mq.size() != 0)
      chk({tag, ".head"},
          {evt_ext, evt_brk, evt_code}, mq[0]);
  endtask

  task automatic check_reset_outs(string tag);
    chk(tag, {key_held, key_press, key_release,
              evt_valid, evt_code, evt_ext, evt_brk,
              frame_err, fifo_ovf}, 0);
  endtask

  typedef struct {
    logic [7:0]    b;
    bit            bp;
    bit            bs;
    logic [NK-1:0] held;
  } vec_t;

  vec_t vt [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         r;
    vt = '{
      '{8'hE0, 0, 0, 8'h00}, '{8'h75, 0, 0, 8'h80},
      '{8'h75, 0, 0, 8'h80}, '{8'hE0, 0, 0, 8'h80},
      '{8'hF0, 0, 0, 8'h80}, '{8'h75, 0, 0, 8'h00},
      '{8'h23, 1, 0, 8'h00}, '{8'h23, 0, 1, 8'h00},
      '{8'h1D, 0, 0, 8'h04}, '{8'hE0, 0, 0, 8'h04},
      '{8'hE0, 0, 0, 8'h04}, '{8'h1D, 0, 0, 8'h04},
      '{8'hF0, 0, 0, 8'h04}, '{8'hF0, 0, 0, 8'h04},
      '{8'h1D, 0, 0, 8'h00}, '{8'hF0, 0, 0, 8'h00},
      '{8'h55, 1, 0, 8'h00}, '{8'h1C, 0, 0, 8'h01},
      '{8'hF0, 0, 0, 8'h01}, '{8'h1C, 0, 0, 8'h00}
    };

    repeat (5) tick();
    check_reset_outs("reset_outs");
    rst_n = 1'b1;
    repeat (10) tick();

    // single make: latency and head contents
    send(8'h1C, 0, 0, 0);
    chk("first_latency", last_press_cyc - fall_cyc, 12);
    chk("first_code", evt_code, 8'h1C);
    chk("first_flags", {evt_ext, evt_brk}, 0);
    chk("first_held0", key_held[0], 1);
    check_state("first");
    drain();
    send(8'hF0, 0, 0, 0);
    send(8'h1C, 0, 0, 0);
    drain();

    // typematic repeats then break, no pops
    send(8'h1C, 0, 0, 0);
    send(8'h1C, 0, 0, 0);
    send(8'h1C, 0, 0, 0);
    send(8'hF0, 0, 0, 0);
    send(8'h1C, 0, 0, 0);
    check_state("typematic");
    drain();

    // table vectors
    foreach (vt[n]) begin
      send(vt[n].b, vt[n].bp, vt[n].bs, 0);
      chk($sformatf("vec%0d.held", n), key_held,
          vt[n].held);
      check_state($sformatf("vec%0d", n));
      drain();
    end

    // break prefix then a frame that times out
    send(8'hF0, 0, 0, 0);
    bitx(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) bitx(1'b1, 1'b0);
    ps2_data = 1'b1;
    repeat (TO + 10) tick();
    model_byte(8'h00, 0);
    check_state("timeout");
    send(8'h1D, 0, 0, 0);
    chk("timeout_press2", o_press[2], m_press[2]);
    check_state("after_timeout");
    drain();

    // overflow with no pop
    send(8'h1C, 0, 0, 0);
    send(8'h23, 0, 0, 0);
    send(8'h1B, 0, 0, 0);
    send(8'h5A, 0, 0, 0);
    send(8'h16, 0, 0, 0);
    check_state("ovf");
    drain();

    // full FIFO with pop around the fifth push
    send(8'hF0, 0, 0, 0);
    send(8'h1C, 0, 0, 0);
    send(8'h1C, 0, 0, 0);
    send(8'h23, 0, 0, 0);
    send(8'h1E, 0, 0, 0);
    send(8'h16, 0, 0, 1);
    check_state("ovf_pop");
    drain();

    // short low spikes while data looks like a start bit
    ps2_data = 1'b0;
    for (int s = 0; s < 6; s++) begin
      ps2_clk = 1'b0;
      repeat (3) tick();
      ps2_clk = 1'b1;
      repeat (12) tick();
    end
    ps2_data = 1'b1;
    repeat (TO / 4) tick();
    check_state("glitch");
    send(8'h1C, 0, 0, 0);
    check_state("after_glitch");
    drain();

    // reset in the middle of a frame
    bitx(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) bitx(1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    check_reset_outs("midreset_outs");
    repeat (3) tick();
    rst_n = 1'b1;
    m_held = '0;
    m_ext = 0;
    m_brk = 0;
    mq.delete();
    ps2_data = 1'b1;
    repeat (50) tick();
    send(8'h1C, 0, 0, 0);
    check_state("after_reset");
    drain();

    // random frames with random pops
    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        case ($urandom_range(0, 7))
          0: b = 8'h1C; 1: b = 8'h23;
          2: b = 8'h1D; 3: b = 8'h1B;
          4: b = 8'h5A; 5: b = 8'h16;
          6: b = 8'h1E; default: b = 8'h75;
        endcase
      end else if (r < 45) begin
        b = 8'hE0;
      end else if (r < 65) begin
        b = 8'hF0;
      end else begin
        b = 8'($urandom_range(0, 254));
      end
      r = $urandom_range(0, 99);
      send(b, r < 4, r >= 4 && r < 8, 0);
      check_state($sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) pop();
    end
    drain();
    check_state("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
